dmi_jtag_ctrl: RTL

DMI_JTAG_CTRL -- requirements
Module: dmi_jtag_ctrl

---
 rtl/dmi_jtag_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dmi_jtag_ctrl.sv
// JTAG-side DMI controller: dtmcs/dmi shift registers, request/response FSM, sticky error.
// Optional WAIT-state response timeout is enabled by defining DMI_TIMEOUT_EN.
module dmi_jtag_ctrl #(
    parameter int unsigned IdleCycles    = 1,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        tck_i,
    input  logic        trst_ni,
    input  logic        capture_dr_i,
    input  logic        shift_dr_i,
    input  logic        update_dr_i,
    input  logic        dtmcs_select_i,
    input  logic        dmi_select_i,
    input  logic        tdi_i,
    output logic        tdo_o,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    output logic        dmi_cdc_clear_o
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] READ       = 3'd1;
    localparam logic [2:0] WAIT_READ  = 3'd2;
    localparam logic [2:0] WRITE      = 3'd3;
    localparam logic [2:0] WAIT_WRITE = 3'd4;
    localparam logic [2:0] IDLE_FIELD = 3'(IdleCycles);

    logic [2:0]  state_r, state_s;
    logic [1:0]  error_r, error_s;
    logic [6:0]  addr_r, addr_s;
    logic [31:0] data_r, data_s;
    logic        clear_r, clear_s;
    logic [31:0] dtmcs_sr_r;
    logic [40:0] dmi_sr_r;
    logic [31:0] dtmcs_value_s;
    logic [1:0]  op_s;
    logic        waiting_s;
    logic        timeout_s;

    assign dtmcs_value_s = {17'd0, IDLE_FIELD, error_r, 6'd7, 4'd1};
    assign waiting_s     = (state_r == WAIT_READ) || (state_r == WAIT_WRITE);

`ifdef DMI_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 255) ? $clog2(TimeoutCycles + 1) : 8;
    logic [CntW-1:0] cnt_r, cnt_s;

    assign timeout_s = waiting_s && (cnt_r == CntW'(TimeoutCycles - 1));

    // Counter restarts on every state change and only advances while waiting.
    always_comb begin
        cnt_s = '0;
        if (state_s != state_r) begin
            cnt_s = '0;
        end else if (waiting_s) begin
            cnt_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; dtmcs hardreset has final say over everything else.
    always_comb begin
        state_s = state_r;
        error_s = error_r;
        addr_s  = addr_r;
        data_s  = data_r;
        clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (dmi_select_i && update_dr_i && (error_r == 2'd0)) begin
                    addr_s = dmi_sr_r[40:34];
                    data_s = dmi_sr_r[33:2];
                    case (dmi_sr_r[1:0])
                        2'd1:    state_s = READ;
                        2'd2:    state_s = WRITE;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (dmi_req_ready_i) state_s = WAIT_READ;
                else                 state_s = READ;
            end
            WRITE: begin
                if (dmi_req_ready_i) state_s = WAIT_WRITE;
                else                 state_s = WRITE;
            end
            WAIT_READ, WAIT_WRITE: begin
                if (dmi_resp_valid_i) begin
                    if (state_r == WAIT_READ) data_s = dmi_resp_i[33:2];
                    else                      data_s = data_r;
                    if ((dmi_resp_i[1:0] != 2'd0) && (error_r == 2'd0)) error_s = 2'd2;
                    else                                                 error_s = error_r;
                    state_s = IDLE;
                end else if (timeout_s) begin
                    error_s = 2'd2;
                    clear_s = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = IDLE;
        endcase
        if (dmi_select_i && (capture_dr_i || update_dr_i) && (state_r != IDLE)) begin
            error_s = 2'd3;
        end else begin
            error_s = error_s;
        end
        if (dtmcs_select_i && update_dr_i) begin
            if (dtmcs_sr_r[17]) begin
                state_s = IDLE;
                error_s = 2'd0;
                clear_s = 1'b1;
            end else if (dtmcs_sr_r[16]) begin
                error_s = 2'd0;
            end else begin
                error_s = error_s;
            end
        end else begin
            clear_s = clear_s;
        end
    end

    // Control state registers.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_r <= IDLE;
            error_r <= 2'd0;
            addr_r  <= 7'd0;
            data_r  <= 32'd0;
            clear_r <= 1'b0;
        end else begin
            state_r <= state_s;
            error_r <= error_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            clear_r <= clear_s;
        end
    end

    // Capture/shift of the two data registers; tdi enters at the MSB.
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            dtmcs_sr_r <= 32'd0;
            dmi_sr_r   <= 41'd0;
        end else if (capture_dr_i) begin
            if (dtmcs_select_i) dtmcs_sr_r <= dtmcs_value_s;
            if (dmi_select_i)   dmi_sr_r   <= {addr_r, data_r, error_r};
        end else if (shift_dr_i) begin
            if (dtmcs_select_i) dtmcs_sr_r <= {tdi_i, dtmcs_sr_r[31:1]};
            if (dmi_select_i)   dmi_sr_r   <= {tdi_i, dmi_sr_r[40:1]};
        end
    end

    // Output decodes straight from registered state.
    always_comb begin
        case (state_r)
            READ:    op_s = 2'd1;
            WRITE:   op_s = 2'd2;
            default: op_s = 2'd0;
        endcase
        if (dtmcs_select_i)    tdo_o = dtmcs_sr_r[0];
        else if (dmi_select_i) tdo_o = dmi_sr_r[0];
        else                   tdo_o = 1'b0;
    end

    assign dmi_req_o        = {addr_r, data_r, op_s};
    assign dmi_req_valid_o  = (state_r == READ) || (state_r == WRITE);
    assign dmi_resp_ready_o = waiting_s;
    assign dmi_cdc_clear_o  = clear_r;

endmodule
